mem: RTL and testbench

MEM -- requirements
Module: mem

---
 rtl/mem.sv | 166 ++++++++++++++++
 tb/tb_mem.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem.sv
// Tagged, fixed-latency backing memory: byte-addressed loads/stores of 1/2/4/8 bytes
// over an array of 64-bit lines, with out-of-order-free load returns MEM_LATENCY_IN_CYCLES later.
module mem #(
    parameter int MEM_64BIT_LINES       = 8192,
    parameter int MEM_LATENCY_IN_CYCLES = 10,
    parameter int NUM_MEM_TAGS          = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
`ifndef CACHE_MODE
    input  logic [1:0]  proc2mem_size,
`endif
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);

    localparam int IDX_W = $clog2(MEM_64BIT_LINES);
    localparam int LAT   = MEM_LATENCY_IN_CYCLES;

    logic [63:0] unified_memory [MEM_64BIT_LINES];

    logic [1:0]       size;
    logic [28:0]      line;
    logic [2:0]       off;
    logic [IDX_W-1:0] idx;

`ifdef CACHE_MODE
    assign size = 2'd3;
`else
    assign size = proc2mem_size;
`endif
    assign line = proc2mem_addr[31:3];
    assign off  = proc2mem_addr[2:0];
    assign idx  = line[IDX_W-1:0];

    logic is_load, is_store, in_range, aligned, req_ok;

    assign is_load  = (proc2mem_command == 2'd1);
    assign is_store = (proc2mem_command == 2'd2);
    assign in_range = ({3'b000, line} < 32'(MEM_64BIT_LINES));
    assign req_ok   = (is_load || is_store) && in_range && aligned;

    always_comb begin
        aligned = 1'b0;
        case (size)
            2'd0: aligned = 1'b1;
            2'd1: aligned = ~off[0];
            2'd2: aligned = (off[1:0] == 2'b00);
            2'd3: aligned = (off == 3'b000);
            default: aligned = 1'b0;
        endcase
    end

    logic [NUM_MEM_TAGS:1] busy;
    logic [3:0]            free_tag;
    logic                  any_free;

    // Downward scan so the last assignment wins: the lowest-numbered free tag.
    always_comb begin
        free_tag = 4'd0;
        any_free = 1'b0;
        for (int t = NUM_MEM_TAGS; t >= 1; t--) begin
            if (!busy[t]) begin
                free_tag = 4'(t);
                any_free = 1'b1;
            end
        end
    end

    // Handshake: a request is accepted on the rising edge where mem2proc_response is
    // nonzero; a zero response leaves no trace and the requester holds and retries.
    always_comb begin
        mem2proc_response = 4'd0;
        if (reset_n && req_ok) begin
            if (any_free)
                mem2proc_response = free_tag;
            else if (is_store)
                mem2proc_response = 4'd1;
        end
    end

    logic load_accept, store_accept;

    assign load_accept  = (mem2proc_response != 4'd0) && is_load;
    assign store_accept = (mem2proc_response != 4'd0) && is_store;

    logic [7:0]  size_bytes;
    logic [63:0] size_field;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] cur_line;
    logic [63:0] merged;
    logic [63:0] rdata;

    always_comb begin
        size_bytes = 8'h00;
        size_field = 64'd0;
        case (size)
            2'd0: begin size_bytes = 8'h01; size_field = 64'h0000_0000_0000_00FF; end
            2'd1: begin size_bytes = 8'h03; size_field = 64'h0000_0000_0000_FFFF; end
            2'd2: begin size_bytes = 8'h0F; size_field = 64'h0000_0000_FFFF_FFFF; end
            2'd3: begin size_bytes = 8'hFF; size_field = 64'hFFFF_FFFF_FFFF_FFFF; end
            default: begin size_bytes = 8'h00; size_field = 64'd0; end
        endcase
    end

    assign cur_line = unified_memory[idx];
    assign wmask    = size_bytes << off;
    assign wdata    = proc2mem_data << {off, 3'b000};
    assign rdata    = (cur_line >> {off, 3'b000}) & size_field;

    always_comb begin
        merged = cur_line;
        for (int b = 0; b < 8; b++) begin
            if (wmask[b])
                merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    // Memory is deliberately outside the reset domain so preloaded contents survive reset.
    always_ff @(posedge clk) begin
        if (store_accept)
            unified_memory[idx] <= merged;
    end

    logic [3:0]            pipe_tag  [LAT];
    logic [63:0]           pipe_data [LAT];
    logic [NUM_MEM_TAGS:1] ret_mask;
    logic [NUM_MEM_TAGS:1] acc_mask;

    always_comb begin
        ret_mask = '0;
        acc_mask = '0;
        for (int t = 1; t <= NUM_MEM_TAGS; t++) begin
            ret_mask[t] = (mem2proc_tag == 4'(t));
            acc_mask[t] = load_accept && (mem2proc_response == 4'(t));
        end
    end

    // The last stage is the output register, so a load surfaces LAT-1 edges after stage 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_tag[i]  <= 4'd0;
                pipe_data[i] <= 64'd0;
            end
            busy <= '0;
        end else begin
            pipe_tag[0]  <= load_accept ? mem2proc_response : 4'd0;
            pipe_data[0] <= load_accept ? rdata : 64'd0;
            for (int i = 1; i < LAT; i++) begin
                pipe_tag[i]  <= pipe_tag[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
            busy <= (busy & ~ret_mask) | acc_mask;
        end
    end

    assign mem2proc_tag  = pipe_tag[LAT-1];
    assign mem2proc_data = pipe_data[LAT-1];

endmodule

// File: tb/tb_mem.sv
// Directed plus random stimulus for mem, checked every cycle against a
// transaction-level model (array memory, busy-tag set, queue of dated returns).
module tb_mem;

    localparam int LINES = 8192;
    localparam int LAT   = 20;
    localparam int NTAGS = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [1:0]  proc2mem_size;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    always #5 clk = ~clk;

    mem #(
        .MEM_64BIT_LINES      (LINES),
        .MEM_LATENCY_IN_CYCLES(LAT),
        .NUM_MEM_TAGS         (NTAGS)
    ) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .proc2mem_command (proc2mem_command),
        .proc2mem_addr    (proc2mem_addr),
        .proc2mem_data    (proc2mem_data),
`ifndef CACHE_MODE
        .proc2mem_size    (proc2mem_size),
`endif
        .mem2proc_response(mem2proc_response),
        .mem2proc_data    (mem2proc_data),
        .mem2proc_tag     (mem2proc_tag)
    );

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
    } ret_t;

    ret_t        exp_q[$];
    logic [63:0] mem_m [LINES];
    logic [NTAGS:0] busy_m;
    int          cyc;
    int          checks;
    int          errors;
    logic        rn;
    logic [3:0]  exp_resp;
    logic [3:0]  dut_resp;

    function automatic logic [3:0] model_resp(logic ok, logic [1:0] cmd, logic [31:0] addr,
                                              logic [1:0] size);
        if (!ok) return 4'd0;
        if (cmd != 2'd1 && cmd != 2'd2) return 4'd0;
        if (int'(addr[31:3]) >= LINES) return 4'd0;
        if ((addr % (32'd1 << size)) != 0) return 4'd0;
        for (int t = 1; t <= NTAGS; t++)
            if (!busy_m[t]) return 4'(t);
        return (cmd == 2'd2) ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [63:0] extract(logic [63:0] ln, int off, int size);
        logic [63:0] v;
        v = 64'd0;
        for (int b = 0; b < (1 << size); b++)
            v[8*b +: 8] = ln[8*(off+b) +: 8];
        return v;
    endfunction

    task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic step(logic [1:0] cmd, logic [31:0] addr, logic [63:0] data, logic [1:0] size);
        logic [3:0]  et;
        logic [63:0] ed;
        int          li;
        int          off;
        @(negedge clk);
        reset_n          = rn;
        proc2mem_command = cmd;
        proc2mem_addr    = addr;
        proc2mem_data    = data;
        proc2mem_size    = size;
        if (!rn) begin
            busy_m = '0;
            exp_q.delete();
        end
        #1;
        exp_resp = model_resp(rn, cmd, addr, size);
        dut_resp = mem2proc_response;
        check("response", mem2proc_response, exp_resp);
        et = 4'd0;
        ed = 64'd0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            et = exp_q[0].tag;
            ed = exp_q[0].data;
        end
        check("ret_tag", mem2proc_tag, et);
        check("ret_data", mem2proc_data, ed);
        @(posedge clk);
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc - 1) begin
            busy_m[exp_q[0].tag] = 1'b0;
            void'(exp_q.pop_front());
        end
        if (exp_resp != 4'd0) begin
            li  = int'(addr[31:3]);
            off = int'(addr[2:0]);
            if (cmd == 2'd1) begin
                busy_m[exp_resp] = 1'b1;
                exp_q.push_back('{cyc + LAT - 1, exp_resp, extract(mem_m[li], off, int'(size))});
            end else begin
                for (int b = 0; b < (1 << size); b++)
                    mem_m[li][8*(off+b) +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(2'd0, 32'd0, 64'd0, 2'd0);
    endtask

    task automatic compare_mem();
        for (int i = 0; i < 16; i++) check("mem_line", u_dut.unified_memory[i], mem_m[i]);
        check("mem_last_line", u_dut.unified_memory[LINES-1], mem_m[LINES-1]);
    endtask

    initial begin
        logic [1:0]  c;
        logic [1:0]  s;
        logic [31:0] a;
        int          ln;
        int          off;
        int          n;

        checks = 0;
        errors = 0;
        cyc    = 0;
        busy_m = '0;
        rn     = 1'b0;
        reset_n          = 1'b0;
        proc2mem_command = 2'd0;
        proc2mem_addr    = 32'd0;
        proc2mem_data    = 64'd0;
        proc2mem_size    = 2'd0;
        for (int i = 0; i < LINES; i++) mem_m[i] = {$urandom, $urandom};
        mem_m[0] = 64'h0123_4567_89AB_CDEF;
        mem_m[2] = 64'h1122_3344_5566_7788;
        for (int i = 0; i < LINES; i++) u_dut.unified_memory[i] = mem_m[i];

        // Reset: outputs idle and requests refused while reset_n is low.
        step(2'd1, 32'd0, 64'd0, 2'd3);
        step(2'd2, 32'd8, 64'hDEAD, 2'd3);
        rn = 1'b1;

        // Doubleword load of the preloaded line 0.
        step(2'd1, 32'h0, 64'd0, 2'd3);
        idle(LAT + 2);

        // Byte store into line 2 then word load covering it.
        step(2'd2, 32'h13, 64'hFFFF_FFFF_FFFF_FFAA, 2'd0);
        step(2'd1, 32'h10, 64'd0, 2'd2);
        step(2'd1, 32'h10, 64'd0, 2'd3);

        // Load before store returns old value; load after store sees new one.
        step(2'd1, 32'h28, 64'd0, 2'd3);
        step(2'd2, 32'h28, {$urandom, $urandom}, 2'd3);
        step(2'd1, 32'h28, 64'd0, 2'd3);
        step(2'd2, 32'h2A, 64'h0000_0000_0000_BEEF, 2'd1);
        step(2'd1, 32'h2C, 64'd0, 2'd2);

        // Invalid requests: out of range, misaligned, reserved command.
        step(2'd1, 32'h10000, 64'd0, 2'd3);
        step(2'd1, 32'h3, 64'd0, 2'd1);
        step(2'd1, 32'h6, 64'd0, 2'd2);
        step(2'd2, 32'h10000, 64'h55, 2'd0);
        step(2'd3, 32'h0, 64'd0, 2'd3);
        step(2'd1, 32'((LINES - 1) * 8), 64'd0, 2'd3);
        idle(LAT + 2);

        // Tag exhaustion: 15 loads, store still granted tag 1, 16th load waits.
        for (int i = 0; i < NTAGS; i++) step(2'd1, 32'(i * 8), 64'd0, 2'd3);
        step(2'd2, 32'h40, 64'h1234_5678_9ABC_DEF0, 2'd3);
        check("store_when_full", dut_resp, 4'd1);
        n = 0;
        do begin
            step(2'd1, 32'h40, 64'd0, 2'd3);
            n++;
        end while (exp_resp == 4'd0 && n < 60);
        check("load16_tag1", dut_resp, 4'd1);
        idle(LAT + 2);

        // Reset with three loads in flight.
        step(2'd1, 32'h8, 64'd0, 2'd3);
        step(2'd1, 32'h18, 64'd0, 2'd3);
        step(2'd1, 32'h20, 64'd0, 2'd3);
        idle(2);
        rn = 1'b0;
        step(2'd1, 32'h0, 64'd0, 2'd3);
        step(2'd2, 32'h0, 64'hFFFF, 2'd3);
        idle(2);
        rn = 1'b1;
        idle(LAT + 3);
        step(2'd1, 32'h0, 64'd0, 2'd3);
        check("tag_after_reset", dut_resp, 4'd1);
        compare_mem();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            c = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            n = $urandom_range(0, 19);
            if (n == 0)      ln = LINES;
            else if (n == 1) ln = LINES - 1;
            else             ln = $urandom_range(0, 15);
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 9) != 0) off = (off >> s) << s;
            a = 32'(ln * 8 + off);
            step(c, a, {$urandom, $urandom}, s);
        end
        idle(LAT + 2);
        compare_mem();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
